// File: rtl/pong_pkg.sv
// Shared constants and types for the pong datapath: screen geometry, paddle FSM states,
// direction encoding and the wall-clamped position step.
package pong_pkg;

  localparam int SCREEN_H = 768;
  localparam int PADDLE_H = 80;

  typedef enum logic [1:0] {HOLD, RAMP, CRUISE} pstate_e;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

  // Move y by s toward dir, saturating at 0 and ymax (13-bit unsigned throughout).
  function automatic logic [12:0] step_pos(input logic [12:0] y, input logic [12:0] s,
                                           input dir_e dir, input logic [12:0] ymax);
    if (dir == UP) return (y < s) ? 13'd0 : y - s;
    return (y + s > ymax) ? ymax : y + s;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level into the pclk domain.
module sync2 (
  input  logic pclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/paddle_ctl.sv
// Player paddle position controller: once per frame (vblank rise) samples the buttons
// and moves y_pos with speed ramping and wall clamping.
module paddle_ctl
  import pong_pkg::*;
#(
  parameter int SCREEN_H     = pong_pkg::SCREEN_H,
  parameter int PADDLE_H     = pong_pkg::PADDLE_H,
  parameter int SPEED_MIN    = 2,
  parameter int SPEED_MAX    = 8,
  parameter int SPEED_STEP   = 2,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        recentre,
  output logic [11:0] y_pos,
  output logic        frame_tick,
  output logic        moving
);

  localparam int CW = $clog2(ACCEL_FRAMES) + 1;
  localparam logic [12:0]   Y_MAX    = 13'(SCREEN_H - PADDLE_H);
  localparam logic [12:0]   Y_CENTRE = 13'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [7:0]    S_MIN    = 8'(SPEED_MIN);
  localparam logic [7:0]    S_MAX    = 8'(SPEED_MAX);
  localparam logic [7:0]    S_STEP   = 8'(SPEED_STEP);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCEL_FRAMES - 1);

  logic up_s, down_s, rec_s;

  sync2 u_sync_up   (.pclk(pclk), .rst(rst), .d(btn_up),   .q(up_s));
  sync2 u_sync_down (.pclk(pclk), .rst(rst), .d(btn_down), .q(down_s));
  sync2 u_sync_rec  (.pclk(pclk), .rst(rst), .d(recentre), .q(rec_s));

  pstate_e       state, state_nx;
  dir_e          dir_r, dir_nx, dir_c;
  logic [7:0]    speed, speed_nx, spd_inc;
  logic [CW-1:0] frame_cnt, cnt_nx;
  logic [12:0]   y13, y_nx, step;
  logic          vblnk_d, tick;

  // vblnk_d resets high so a vblank already active at reset release is not a tick.
  assign tick    = vblnk_in & ~vblnk_d;
  assign y13     = {1'b0, y_pos};
  assign dir_c   = dir_e'(down_s);
  assign spd_inc = speed + S_STEP;

  always_comb begin
    state_nx = state;
    speed_nx = speed;
    cnt_nx   = frame_cnt;
    dir_nx   = dir_r;
    y_nx     = y13;
    step     = 13'(S_MIN);
    if (rec_s) begin
      y_nx     = Y_CENTRE;
      state_nx = HOLD;
      speed_nx = S_MIN;
      cnt_nx   = '0;
    end else if (up_s == down_s) begin
      state_nx = HOLD;
      speed_nx = S_MIN;
      cnt_nx   = '0;
    end else begin
      if (state == HOLD || dir_c != dir_r) begin
        // fresh start or reversal: restart the ramp at minimum speed
        step     = 13'(S_MIN);
        dir_nx   = dir_c;
        speed_nx = S_MIN;
        cnt_nx   = CW'(1);
        state_nx = RAMP;
      end else if (state == CRUISE) begin
        step = 13'(S_MAX);
      end else begin
        step = 13'(speed);
        if (frame_cnt == CNT_LAST) begin
          speed_nx = (spd_inc > S_MAX) ? S_MAX : spd_inc;
          cnt_nx   = '0;
        end else begin
          cnt_nx = frame_cnt + CW'(1);
        end
        if (speed_nx == S_MAX) state_nx = CRUISE;
      end
      y_nx = step_pos(y13, step, dir_c, Y_MAX);
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vblnk_d    <= 1'b1;
      frame_tick <= 1'b0;
      y_pos      <= Y_CENTRE[11:0];
      moving     <= 1'b0;
      state      <= HOLD;
      speed      <= S_MIN;
      frame_cnt  <= '0;
      dir_r      <= UP;
    end else begin
      vblnk_d    <= vblnk_in;
      frame_tick <= tick;
      if (tick) begin
        y_pos     <= y_nx[11:0];
        moving    <= (y_nx != y13);
        state     <= state_nx;
        speed     <= speed_nx;
        frame_cnt <= cnt_nx;
        dir_r     <= dir_nx;
      end
    end
  end

endmodule

// File: tb/tb_paddle_ctl.sv
// Directed bench for paddle_ctl: ramp schedule, wall clamps, reversal, recentre and async reset.
module tb_paddle_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk_in, btn_up, btn_down, recentre;
  logic [11:0] y_pos;
  logic        frame_tick, moving;

  int n_chk = 0;
  int n_err = 0;
  int ey;        // expected y_pos
  int run_k;     // frames into the current same-direction run
  int last_dir;

  paddle_ctl dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .btn_up(btn_up), .btn_down(btn_down),
    .recentre(recentre), .y_pos(y_pos), .frame_tick(frame_tick), .moving(moving)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One frame: drop vblank, let buttons settle through the synchronisers, raise vblank.
  task automatic frame();
    @(negedge pclk) vblnk_in = 1'b0;
    repeat (4) @(negedge pclk);
    vblnk_in = 1'b1;
    @(negedge pclk);
    check("frame_tick", int'(frame_tick), 1);
  endtask

  // Hand schedule: 8 frames at 2, 8 at 4, 8 at 6, then 8 per frame.
  function automatic int sched(input int k);
    if (k <= 8)  return 2;
    if (k <= 16) return 4;
    if (k <= 24) return 6;
    return 8;
  endfunction

  task automatic press(input bit u, input bit d, input int n, input string tag);
    int old, s;
    btn_up   = u;
    btn_down = d;
    for (int i = 0; i < n; i++) begin
      old = ey;
      if (u == d) begin
        run_k = 0;
      end else begin
        if (run_k > 0 && int'(d) != last_dir) run_k = 0;
        last_dir = int'(d);
        run_k++;
        s = sched(run_k);
        if (d) ey = (ey + s > 688) ? 688 : ey + s;
        else   ey = (ey < s) ? 0 : ey - s;
      end
      frame();
      check({tag, "_y"}, int'(y_pos), ey);
      check({tag, "_moving"}, int'(moving), int'(ey != old));
    end
  endtask

  initial begin
    int seen;
    rst = 1'b0; vblnk_in = 1'b1; btn_up = 1'b0; btn_down = 1'b0; recentre = 1'b0;
    ey = 344; run_k = 0; last_dir = 0;
    repeat (3) @(negedge pclk);
    check("rst_y", int'(y_pos), 344);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_moving", int'(moving), 0);

    // release with vblank already high: no tick
    rst = 1'b1;
    seen = 0;
    repeat (6) @(negedge pclk) if (frame_tick) seen = 1;
    check("no_tick_at_release", seen, 0);
    press(0, 0, 1, "idle");

    // down ramp through CRUISE: 360 after 8, 392 after 16, 440 after 24
    press(0, 1, 8, "down_a");
    check("down_8", int'(y_pos), 360);
    press(0, 1, 8, "down_b");
    check("down_16", int'(y_pos), 392);
    press(0, 1, 8, "down_c");
    check("down_24", int'(y_pos), 440);
    press(0, 1, 2, "cruise");
    check("cruise_26", int'(y_pos), 456);

    // both pressed: no move, speed back to minimum
    press(1, 1, 1, "both");
    press(0, 1, 1, "restart");
    check("restart_step2", int'(y_pos), 458);

    // continue down into the bottom wall and beyond
    press(0, 1, 45, "down_wall");
    check("bottom_wall", int'(y_pos), 688);

    // recentre wins over held down
    recentre = 1'b1;
    ey = 344; run_k = 0;
    frame();
    check("recentre_y", int'(y_pos), 344);
    check("recentre_moving", int'(moving), 1);
    recentre = 1'b0;
    press(0, 1, 1, "after_rec");
    check("after_rec_y", int'(y_pos), 346);

    // up into the top wall: 346-16-32-48 = 250, then 8/frame, clamps at 0
    press(1, 0, 58, "up_wall");
    check("top_wall", int'(y_pos), 0);

    // down to speed 6, then reverse: up restarts at 2
    press(0, 1, 20, "down_rev");
    check("down_20", int'(y_pos), 72);
    press(1, 0, 8, "rev_up");
    check("rev_8", int'(y_pos), 56);
    press(1, 0, 1, "rev_up9");
    check("rev_9", int'(y_pos), 52);

    // async reset mid-ramp, while frame_tick is high
    btn_up = 1'b0; btn_down = 1'b1;
    frame();
    #1 rst = 1'b0;
    #1;
    check("midrst_y", int'(y_pos), 344);
    check("midrst_tick", int'(frame_tick), 0);
    check("midrst_moving", int'(moving), 0);
    @(negedge pclk) rst = 1'b1;
    ey = 344; run_k = 0;
    press(0, 1, 1, "post_rst");
    check("post_rst_y", int'(y_pos), 346);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
